// File: rtl/sweep_step_ctrl.sv
// Step sequencer for one axis: issues up/down step codes at a programmable rate,
// tracks position and bounces between captured limits for a set number of reversals.
module sweep_step_ctrl #(
    parameter int POS_W = 8,
    parameter int DIV_W = 16,
    parameter int SWP_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic [POS_W-1:0] lim_lo,
    input  logic [POS_W-1:0] lim_hi,
    input  logic [DIV_W-1:0] div,
    input  logic [SWP_W-1:0] sweeps,
    output logic [1:0]       o_step,
    output logic [POS_W-1:0] pos,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             at_lo,
    output logic             at_hi
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_UP   = 2'd1,
        S_DOWN = 2'd2
    } state_t;

    localparam logic [1:0]       STEP_IDLE = 2'b00;
    localparam logic [1:0]       STEP_UP   = 2'b10;
    localparam logic [1:0]       STEP_DN   = 2'b01;
    localparam logic [POS_W-1:0] POS_ONE   = POS_W'(1);
    localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
    localparam logic [SWP_W-1:0] SWP_ONE   = SWP_W'(1);
    localparam logic [SWP_W:0]   REV_ONE   = (SWP_W + 1)'(1);

    state_t           state_q, state_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic [1:0]       step_q, step_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [SWP_W-1:0] rev_q, rev_d;
    logic [POS_W-1:0] lo_q, lo_d;
    logic [POS_W-1:0] hi_q, hi_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [SWP_W-1:0] swp_q, swp_d;

    logic             tick;
    logic [SWP_W:0]   rev_inc;
    logic             last_rev;

    function automatic logic [SWP_W-1:0] sat_inc(input logic [SWP_W-1:0] v);
        return (&v) ? v : v + SWP_ONE;
    endfunction

    function automatic logic [POS_W-1:0] clamp_pos(
        input logic [POS_W-1:0] p,
        input logic [POS_W-1:0] lo,
        input logic [POS_W-1:0] hi
    );
        if (p < lo)
            return lo;
        else if (p > hi)
            return hi;
        else
            return p;
    endfunction

    assign tick     = (cnt_q == div_q);
    // Wide compare so a saturated counter can never match a nonzero sweep target.
    assign rev_inc  = {1'b0, rev_q} + REV_ONE;
    assign last_rev = (swp_q != '0) && (rev_inc == {1'b0, swp_q});

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        step_d  = STEP_IDLE;
        done_d  = 1'b0;
        err_d   = err_q;
        cnt_d   = cnt_q;
        rev_d   = rev_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        div_d   = div_q;
        swp_d   = swp_q;

        case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    if (lim_lo >= lim_hi) begin
                        err_d = 1'b1;
                    end else begin
                        err_d   = 1'b0;
                        lo_d    = lim_lo;
                        hi_d    = lim_hi;
                        div_d   = div;
                        swp_d   = sweeps;
                        pos_d   = clamp_pos(pos_q, lim_lo, lim_hi);
                        cnt_d   = '0;
                        rev_d   = '0;
                        state_d = (pos_d < lim_hi) ? S_UP : S_DOWN;
                    end
                end
            end

            S_UP: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (tick) begin
                    cnt_d  = '0;
                    pos_d  = pos_q + POS_ONE;
                    step_d = STEP_UP;
                    if (pos_d == hi_q) begin
                        rev_d = sat_inc(rev_q);
                        if (last_rev) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_DOWN;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + DIV_ONE;
                end
            end

            S_DOWN: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (tick) begin
                    cnt_d  = '0;
                    pos_d  = pos_q - POS_ONE;
                    step_d = STEP_DN;
                    if (pos_d == lo_q) begin
                        rev_d = sat_inc(rev_q);
                        if (last_rev) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_UP;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + DIV_ONE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            pos_q   <= '0;
            step_q  <= STEP_IDLE;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            rev_q   <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            div_q   <= '0;
            swp_q   <= '0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            step_q  <= step_d;
            done_q  <= done_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            rev_q   <= rev_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            div_q   <= div_d;
            swp_q   <= swp_d;
        end
    end

    assign o_step = step_q;
    assign pos    = pos_q;
    assign busy   = (state_q != S_IDLE);
    assign done   = done_q;
    assign err    = err_q;
    assign at_lo  = (pos_q == lo_q);
    assign at_hi  = (pos_q == hi_q);

endmodule

// File: tb/tb_sweep_step_ctrl.sv
// Directed bench for sweep_step_ctrl: limit bounce, rate divider, sweep count,
// error rejection, stop/start priority, reset and full-range travel.
module tb_sweep_step_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        stop;
    logic [7:0]  lim_lo;
    logic [7:0]  lim_hi;
    logic [15:0] div;
    logic [7:0]  sweeps;
    logic [1:0]  o_step;
    logic [7:0]  pos;
    logic        busy;
    logic        done;
    logic        err;
    logic        at_lo;
    logic        at_hi;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sweep_step_ctrl #(.POS_W(8), .DIV_W(16), .SWP_W(8)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .stop   (stop),
        .lim_lo (lim_lo),
        .lim_hi (lim_hi),
        .div    (div),
        .sweeps (sweeps),
        .o_step (o_step),
        .pos    (pos),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .at_lo  (at_lo),
        .at_hi  (at_hi)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout got 1 expected 0");
        $fatal(1, "watchdog");
    end

    initial begin
        int t1_pos [7];
        int t1_stp [7];
        int exp_pos;
        int exp_stp;

        t1_pos = '{3, 4, 5, 4, 3, 2, 3};
        t1_stp = '{2, 2, 2, 1, 1, 1, 2};

        reset = 1'b1; start = 1'b0; stop = 1'b0;
        lim_lo = 8'd0; lim_hi = 8'd0; div = 16'd0; sweeps = 8'd0;
        step_clk();
        step_clk();
        check("rst_pos",  32'(pos),    0);
        check("rst_step", 32'(o_step), 0);
        check("rst_busy", 32'(busy),   0);
        check("rst_done", 32'(done),   0);
        check("rst_err",  32'(err),    0);
        reset = 1'b0;

        // Bounce between 2 and 5 at full rate
        lim_lo = 8'd2; lim_hi = 8'd5; div = 16'd0; sweeps = 8'd0;
        start = 1'b1;
        step_clk();
        start = 1'b0;
        check("t1_busy",  32'(busy),   1);
        check("t1_clamp", 32'(pos),    2);
        check("t1_step0", 32'(o_step), 0);
        check("t1_atlo",  32'(at_lo),  1);
        for (int i = 0; i < 7; i++) begin
            step_clk();
            check("t1_pos",  32'(pos),    32'(t1_pos[i]));
            check("t1_step", 32'(o_step), 32'(t1_stp[i]));
            check("t1_athi", 32'(at_hi),  (t1_pos[i] == 5) ? 1 : 0);
        end
        stop = 1'b1;
        step_clk();
        stop = 1'b0;
        check("t1_stop_busy", 32'(busy),   0);
        check("t1_stop_step", 32'(o_step), 0);
        check("t1_stop_pos",  32'(pos),    3);

        // Two reversals with divider 3, then auto-stop
        reset = 1'b1;
        step_clk();
        reset = 1'b0;
        check("t2_rst_pos", 32'(pos), 0);
        lim_lo = 8'd0; lim_hi = 8'd3; div = 16'd3; sweeps = 8'd2;
        start = 1'b1;
        step_clk();
        start = 1'b0;
        check("t2_busy", 32'(busy), 1);
        exp_pos = 0;
        for (int i = 1; i <= 24; i++) begin
            step_clk();
            exp_stp = ((i % 4) == 0) ? ((i <= 12) ? 2 : 1) : 0;
            if (exp_stp == 2) exp_pos++;
            if (exp_stp == 1) exp_pos--;
            check("t2_step", 32'(o_step), 32'(exp_stp));
            check("t2_pos",  32'(pos),    32'(exp_pos));
            check("t2_done", 32'(done),   (i == 24) ? 1 : 0);
            check("t2_busyc", 32'(busy),  (i < 24) ? 1 : 0);
        end
        step_clk();
        check("t2_done_clr", 32'(done), 0);
        check("t2_idle",     32'(busy), 0);

        // Rejected start, then a valid one
        lim_lo = 8'd7; lim_hi = 8'd7;
        start = 1'b1;
        step_clk();
        start = 1'b0;
        check("t3_err",  32'(err),  1);
        check("t3_busy", 32'(busy), 0);
        lim_lo = 8'd1; lim_hi = 8'd4; div = 16'd2; sweeps = 8'd0;
        start = 1'b1;
        step_clk();
        start = 1'b0;
        check("t3_err_clr", 32'(err),  0);
        check("t3_busy2",   32'(busy), 1);
        check("t3_clamp",   32'(pos),  1);

        // Stop on the tick cycle suppresses the step; start+stop in idle does nothing
        step_clk();
        check("t4_nostep1", 32'(o_step), 0);
        step_clk();
        check("t4_nostep2", 32'(o_step), 0);
        stop = 1'b1;
        step_clk();
        stop = 1'b0;
        check("t4_stop_step", 32'(o_step), 0);
        check("t4_stop_pos",  32'(pos),    1);
        check("t4_stop_busy", 32'(busy),   0);
        start = 1'b1; stop = 1'b1;
        step_clk();
        start = 1'b0; stop = 1'b0;
        check("t4_ss_busy", 32'(busy), 0);
        step_clk();
        check("t4_ss_busy2", 32'(busy), 0);
        check("t4_ss_pos",   32'(pos),  1);

        // Start and config changes while busy are ignored; reset mid-sweep
        lim_lo = 8'd0; lim_hi = 8'd9; div = 16'd0; sweeps = 8'd0;
        start = 1'b1;
        step_clk();
        start = 1'b0;
        check("t5_busy", 32'(busy), 1);
        step_clk();
        step_clk();
        step_clk();
        check("t5_pos4", 32'(pos), 4);
        lim_lo = 8'd5; lim_hi = 8'd6; div = 16'd5; sweeps = 8'd1;
        start = 1'b1;
        step_clk();
        start = 1'b0;
        check("t5_pos5",  32'(pos),    5);
        check("t5_step5", 32'(o_step), 2);
        step_clk();
        check("t5_pos6", 32'(pos), 6);
        step_clk();
        check("t5_pos7",  32'(pos),    7);
        check("t5_step7", 32'(o_step), 2);
        check("t5_athi",  32'(at_hi),  0);
        reset = 1'b1;
        step_clk();
        reset = 1'b0;
        check("t5_rst_pos",  32'(pos),    0);
        check("t5_rst_step", 32'(o_step), 0);
        check("t5_rst_busy", 32'(busy),   0);
        check("t5_rst_err",  32'(err),    0);

        // Full 8-bit range without wrap
        lim_lo = 8'd0; lim_hi = 8'd255; div = 16'd0; sweeps = 8'd0;
        start = 1'b1;
        step_clk();
        start = 1'b0;
        check("t6_busy", 32'(busy), 1);
        for (int i = 1; i <= 255; i++) begin
            step_clk();
            check("t6_step", 32'(o_step), 2);
            check("t6_pos",  32'(pos),    32'(i));
        end
        check("t6_athi", 32'(at_hi), 1);
        step_clk();
        check("t6_rev_step", 32'(o_step), 1);
        check("t6_rev_pos",  32'(pos),    254);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
